ahb_lite_master: RTL and testbench

AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

---
 rtl/ahb_lite_master.sv | 119 +++++++++++
 tb/tb_ahb_lite_master.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master: cmd -> NONSEQ, pipelined A/D slots,
// two-cycle ERROR cancel with re-issue, and data-phase wait timeout.
// Ports: hclk/hreset; cmd_* request (valid/ready); rsp_* completion pulse;
//        h* AHB-Lite master signals (hsize/hburst fixed to word/single).
module ahb_lite_master #(
  parameter int ADDR_W   = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              hsel,
  output logic              hwrite,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [31:0]       hwdata,
  input  logic [31:0]       hrdata,
  input  logic              hready,
  input  logic              hresp
);

  // bit0 = address slot valid, bit1 = data slot valid
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10,
    S_AD   = 2'b11
  } state_t;

  localparam logic [7:0] WLIM = 8'(WAIT_MAX - 1);
  localparam logic [ADDR_W-1:0] AMASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t            state_q, state_d;
  logic              cancel_q;
  logic [7:0]        wcnt_q;
  logic [ADDR_W-1:0] haddr_q;
  logic              hwrite_q;
  logic [31:0]       a_wdata_q;
  logic              d_write_q;
  logic [31:0]       hwdata_q;
  logic              rsp_valid_q, rsp_write_q, rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  logic a_v, d_v, abort, accept, adv, done, a_nxt, d_nxt;

  always_comb begin
    a_v = (state_q == S_ADDR) || (state_q == S_AD);
    d_v = (state_q == S_DATA) || (state_q == S_AD);
    // abort on the cycle whose low hready would make the count WAIT_MAX
    abort = d_v && !hready && (wcnt_q == WLIM);
    cmd_ready = !hreset && !abort && !cancel_q && (!a_v || hready);
    accept = cmd_valid && cmd_ready;
    // the cancelled address phase is IDLE on the bus, so A stays put
    adv = a_v && hready && !cancel_q;
    done = d_v && hready;
    d_nxt = adv ? 1'b1 : ((done || abort) ? 1'b0 : d_v);
    a_nxt = abort ? 1'b0 : (accept ? 1'b1 : (adv ? 1'b0 : a_v));
    state_d = state_t'({d_nxt, a_nxt});
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= S_IDLE;
      cancel_q    <= 1'b0;
      wcnt_q      <= 8'd0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      a_wdata_q   <= 32'd0;
      d_write_q   <= 1'b0;
      hwdata_q    <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        haddr_q   <= cmd_addr & AMASK;
        hwrite_q  <= cmd_write;
        a_wdata_q <= cmd_wdata;
      end
      if (adv) begin
        d_write_q <= hwrite_q;
        if (hwrite_q) hwdata_q <= a_wdata_q;
      end
      if (done || abort) cancel_q <= 1'b0;
      else if (d_v && hresp && !hready) cancel_q <= 1'b1;
      if (done || abort) wcnt_q <= 8'd0;
      else if (d_v && !hready) wcnt_q <= wcnt_q + 8'd1;
      rsp_valid_q <= done || abort;
      rsp_write_q <= (done || abort) && d_write_q;
      rsp_rdata_q <= (done && !hresp && !d_write_q) ? hrdata : 32'd0;
      rsp_err_q   <= abort || (done && hresp);
    end
  end

  assign hsel      = a_v;
  assign htrans    = (a_v && !cancel_q) ? 2'b10 : 2'b00;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hsize     = 3'b010;
  assign hburst    = 3'b000;
  assign hwdata    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master with a small word SRAM slave;
// hready/hresp are driven per cycle by the scenario tasks.
module tb_ahb_lite_master;
  localparam int AW = 32;
  localparam int WM = 16;

  logic          hclk = 1'b0;
  logic          hreset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid, rsp_write, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          hsel, hwrite;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic [2:0]    hsize, hburst;
  logic [31:0]   hwdata, hrdata;
  logic          hready, hresp;

  int n_chk = 0;
  int n_pass = 0;

  always #5 hclk = ~hclk;

  ahb_lite_master #(.ADDR_W(AW), .WAIT_MAX(WM)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hsel(hsel), .hwrite(hwrite), .haddr(haddr),
    .htrans(htrans), .hsize(hsize), .hburst(hburst),
    .hwdata(hwdata), .hrdata(hrdata),
    .hready(hready), .hresp(hresp)
  );

  // 4-word SRAM slave, index haddr[3:2]
  logic [31:0] mem [0:3];
  logic        ph_v, ph_w;
  logic [1:0]  ph_i;

  always @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      ph_v <= 1'b0;
      ph_w <= 1'b0;
      ph_i <= 2'd0;
      for (int i = 0; i < 4; i++) mem[i] <= 32'hA5A50000 | 32'(i);
    end else if (hready) begin
      if (ph_v && ph_w && !hresp) mem[ph_i] <= hwdata;
      ph_v <= hsel && (htrans == 2'b10);
      ph_w <= hwrite;
      ph_i <= haddr[3:2];
    end
  end

  assign hrdata = (ph_v && !ph_w) ? mem[ph_i] : 32'h0;

  task automatic tick;
    @(posedge hclk);
    #1;
  endtask

  task automatic do_cmd(input logic w, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd,
                        output logic er, output logic rw,
                        output int lat, output int aw);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr = a;
    cmd_wdata = d;
    aw = 0;
    lat = -1;
    rd = 'x;
    er = 1'bx;
    rw = 1'bx;
    #1;
    while (!cmd_ready && aw < 20) begin
      tick();
      aw++;
    end
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (rsp_valid) begin
        lat = k;
        rd = rsp_rdata;
        er = rsp_err;
        rw = rsp_write;
        break;
      end
    end
  endtask

  task automatic test_reset;
    hreset = 1'b1;
    hready = 1'b1;
    hresp = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 32'h10;
    cmd_wdata = 32'h55AA55AA;
    #3;
    n_chk++;
    if ({htrans, hsel, hwrite} !== 4'b0)
      $display("FAIL rst_ctl got %b exp 0000", {htrans, hsel, hwrite});
    else n_pass++;
    n_chk++;
    if ({haddr, hwdata} !== 64'h0)
      $display("FAIL rst_addr_data got %h exp 0", {haddr, hwdata});
    else n_pass++;
    n_chk++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !== 35'h0)
      $display("FAIL rst_rsp got %h exp 0",
               {rsp_valid, rsp_write, rsp_err, rsp_rdata});
    else n_pass++;
    n_chk++;
    if (cmd_ready !== 1'b0)
      $display("FAIL rst_cmd_ready got %b exp 0", cmd_ready);
    else n_pass++;
    n_chk++;
    if ({hsize, hburst} !== 6'b010_000)
      $display("FAIL hsize_hburst got %b exp 010000", {hsize, hburst});
    else n_pass++;
    tick();
    tick();
    n_chk++;
    if ({htrans, hsel, rsp_valid} !== 4'b0)
      $display("FAIL rst_held got %b exp 0000", {htrans, hsel, rsp_valid});
    else n_pass++;
    cmd_valid = 1'b0;
    #3;
    hreset = 1'b0;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b1)
      $display("FAIL rel_cmd_ready got %b exp 1", cmd_ready);
    else n_pass++;
    tick();
  endtask

  task automatic test_write_read;
    logic [31:0] rd;
    logic er, rw;
    int lat, aw;
    do_cmd(1'b1, 32'h4, 32'hABCD1234, rd, er, rw, lat, aw);
    n_chk++;
    if (lat !== 2) $display("FAIL wr_lat got %0d exp 2", lat);
    else n_pass++;
    n_chk++;
    if ({rw, er, rd} !== {1'b1, 1'b0, 32'h0})
      $display("FAIL wr_rsp got %b %b %h exp 1 0 0", rw, er, rd);
    else n_pass++;
    tick();
    n_chk++;
    if (rsp_valid !== 1'b0)
      $display("FAIL rsp_pulse got %b exp 0", rsp_valid);
    else n_pass++;
    do_cmd(1'b0, 32'h4, 32'h0, rd, er, rw, lat, aw);
    n_chk++;
    if (lat !== 2) $display("FAIL rd_lat got %0d exp 2", lat);
    else n_pass++;
    n_chk++;
    if ({rw, er, rd} !== {1'b0, 1'b0, 32'hABCD1234})
      $display("FAIL rd_rsp got %b %b %h exp 0 0 abcd1234", rw, er, rd);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 32'h0;
    cmd_wdata = 32'hCDEF9876;
    hready = 1'b1;
    tick();
    cmd_write = 1'b0;
    cmd_addr = 32'h4;
    cmd_wdata = 32'h0;
    #1;
    n_chk++;
    if ({htrans, haddr, hwrite, cmd_ready} !== {2'b10, 32'h0, 1'b1, 1'b1})
      $display("FAIL b2b_wr_addr got %h exp 2 0 1 1",
               {htrans, haddr, hwrite, cmd_ready});
    else n_pass++;
    tick();
    cmd_valid = 1'b0;
    n_chk++;
    if ({htrans, haddr, hwrite} !== {2'b10, 32'h4, 1'b0})
      $display("FAIL b2b_rd_addr got %h exp 2 4 0", {htrans, haddr, hwrite});
    else n_pass++;
    n_chk++;
    if (hwdata !== 32'hCDEF9876)
      $display("FAIL b2b_hwdata got %h exp cdef9876", hwdata);
    else n_pass++;
    tick();
    n_chk++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata, htrans} !==
        {1'b1, 1'b1, 1'b0, 32'h0, 2'b00})
      $display("FAIL b2b_wr_rsp got %h exp 1 1 0 0 0",
               {rsp_valid, rsp_write, rsp_err, rsp_rdata, htrans});
    else n_pass++;
    tick();
    n_chk++;
    if ({rsp_valid, rsp_write, rsp_err, rsp_rdata} !==
        {1'b1, 1'b0, 1'b0, 32'hABCD1234})
      $display("FAIL b2b_rd_rsp got %h exp 1 0 0 abcd1234",
               {rsp_valid, rsp_write, rsp_err, rsp_rdata});
    else n_pass++;
  endtask

  task automatic test_wait_states;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 32'h0;
    hready = 1'b1;
    tick();
    cmd_addr = 32'h6;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b1)
      $display("FAIL ws_ready got %b exp 1", cmd_ready);
    else n_pass++;
    tick();
    cmd_valid = 1'b0;
    hready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({haddr, htrans, hwdata, rsp_valid, cmd_ready} !==
          {32'h4, 2'b10, 32'hCDEF9876, 1'b0, 1'b0})
        $display("FAIL ws_stable%0d got %h exp 4 2 cdef9876 0 0", i,
                 {haddr, htrans, hwdata, rsp_valid, cmd_ready});
      else n_pass++;
      tick();
    end
    hready = 1'b1;
    #1;
    n_chk++;
    if (rsp_valid !== 1'b0)
      $display("FAIL ws_early got %b exp 0", rsp_valid);
    else n_pass++;
    tick();
    n_chk++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hCDEF9876})
      $display("FAIL ws_rsp got %h exp 1 0 cdef9876",
               {rsp_valid, rsp_err, rsp_rdata});
    else n_pass++;
    tick();
    n_chk++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'hABCD1234})
      $display("FAIL ws_rsp2 got %h exp 1 0 abcd1234",
               {rsp_valid, rsp_err, rsp_rdata});
    else n_pass++;
  endtask

  task automatic test_error;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 32'h8;
    cmd_wdata = 32'h11112222;
    hready = 1'b1;
    hresp = 1'b0;
    tick();
    cmd_write = 1'b0;
    cmd_wdata = 32'h0;
    tick();
    cmd_valid = 1'b0;
    hresp = 1'b1;
    hready = 1'b0;
    #1;
    n_chk++;
    if ({cmd_ready, htrans} !== 3'b010)
      $display("FAIL err1 got %b exp 010", {cmd_ready, htrans});
    else n_pass++;
    tick();
    hready = 1'b1;
    #1;
    n_chk++;
    if ({htrans, cmd_ready, rsp_valid} !== 4'b0000)
      $display("FAIL err_cancel got %b exp 0000",
               {htrans, cmd_ready, rsp_valid});
    else n_pass++;
    tick();
    hresp = 1'b0;
    #1;
    n_chk++;
    if ({rsp_valid, rsp_err, rsp_write, rsp_rdata} !==
        {1'b1, 1'b1, 1'b1, 32'h0})
      $display("FAIL err_rsp got %h exp 1 1 1 0",
               {rsp_valid, rsp_err, rsp_write, rsp_rdata});
    else n_pass++;
    n_chk++;
    if ({htrans, haddr} !== {2'b10, 32'h8})
      $display("FAIL err_reissue got %h exp 2 8", {htrans, haddr});
    else n_pass++;
    tick();
    n_chk++;
    if (rsp_valid !== 1'b0)
      $display("FAIL err_gap got %b exp 0", rsp_valid);
    else n_pass++;
    tick();
    n_chk++;
    if ({rsp_valid, rsp_err, rsp_write, rsp_rdata} !==
        {1'b1, 1'b0, 1'b0, 32'hA5A50002})
      $display("FAIL err_rd_rsp got %h exp 1 0 0 a5a50002",
               {rsp_valid, rsp_err, rsp_write, rsp_rdata});
    else n_pass++;
  endtask

  task automatic test_timeout;
    logic early, extra;
    logic [31:0] rd;
    logic er, rw;
    int lat, aw;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 32'hC;
    hready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    hready = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_wdata = 32'hDEAD0000;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b1)
      $display("FAIL to_ready got %b exp 1", cmd_ready);
    else n_pass++;
    tick();
    cmd_valid = 1'b0;
    early = 1'b0;
    for (int k = 0; k < WM - 2; k++) begin
      tick();
      if (rsp_valid) early = 1'b1;
    end
    n_chk++;
    if ({early, hsel, htrans} !== 4'b0110)
      $display("FAIL to_wait got %b exp 0110", {early, hsel, htrans});
    else n_pass++;
    tick();
    n_chk++;
    if ({rsp_valid, rsp_err, rsp_write, rsp_rdata} !==
        {1'b1, 1'b1, 1'b0, 32'h0})
      $display("FAIL to_rsp got %h exp 1 1 0 0",
               {rsp_valid, rsp_err, rsp_write, rsp_rdata});
    else n_pass++;
    n_chk++;
    if ({htrans, hsel} !== 3'b000)
      $display("FAIL to_idle got %b exp 000", {htrans, hsel});
    else n_pass++;
    hready = 1'b1;
    extra = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rsp_valid) extra = 1'b1;
    end
    n_chk++;
    if ({extra, cmd_ready} !== 2'b01)
      $display("FAIL to_drop got %b exp 01", {extra, cmd_ready});
    else n_pass++;
    do_cmd(1'b0, 32'hC, 32'h0, rd, er, rw, lat, aw);
    n_chk++;
    if (lat !== 2 || {er, rd} !== {1'b0, 32'hA5A50003})
      $display("FAIL to_next got lat %0d %b %h exp 2 0 a5a50003",
               lat, er, rd);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    logic er, rw, seen;
    int lat, aw;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 32'h4;
    cmd_wdata = 32'h13579BDF;
    hready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    hready = 1'b0;
    n_chk++;
    if (hwdata !== 32'h13579BDF)
      $display("FAIL rm_pre got %h exp 13579bdf", hwdata);
    else n_pass++;
    #2;
    hreset = 1'b1;
    #1;
    n_chk++;
    if ({htrans, hsel, hwrite, haddr, hwdata, cmd_ready, rsp_valid} !== '0)
      $display("FAIL rm_async got %h exp 0",
               {htrans, hsel, hwrite, haddr, hwdata, cmd_ready, rsp_valid});
    else n_pass++;
    seen = 1'b0;
    tick();
    if (rsp_valid) seen = 1'b1;
    tick();
    if (rsp_valid) seen = 1'b1;
    hreset = 1'b0;
    hready = 1'b1;
    #1;
    n_chk++;
    if ({seen, cmd_ready} !== 2'b01)
      $display("FAIL rm_release got %b exp 01", {seen, cmd_ready});
    else n_pass++;
    do_cmd(1'b1, 32'h4, 32'h2468ACE0, rd, er, rw, lat, aw);
    n_chk++;
    if (aw !== 0 || lat !== 2 || er !== 1'b0)
      $display("FAIL rm_wr got aw %0d lat %0d err %b exp 0 2 0",
               aw, lat, er);
    else n_pass++;
    do_cmd(1'b0, 32'h4, 32'h0, rd, er, rw, lat, aw);
    n_chk++;
    if (lat !== 2 || {er, rd} !== {1'b0, 32'h2468ACE0})
      $display("FAIL rm_rd got lat %0d %b %h exp 2 0 2468ace0",
               lat, er, rd);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
